// File: rtl/caeser_inv_lyr.sv
`default_nettype none
// ============================================================================
// Module      : caeser_inv_lyr
// Description : Inverse Caesar layer for the decryption path. Subtracts the
//               shift byte key[127:120] (mod 256) from every byte of a
//               128-bit block, BYTES_PER_CYC bytes per clock, under a
//               valid/ready handshake on both sides.
// Options     : CAE_ZEROIZE_EN - clear data, shift and output registers on
//               the output handshake so no key/plaintext residue remains.
// Revision    : 1.0 - initial release
// ============================================================================
module caeser_inv_lyr #(
  parameter int BYTES_PER_CYC = 4   // legal: 1, 2, 4, 8, 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cae_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cae_out,
  output logic         busy
);

  localparam int NBEATS = 16 / BYTES_PER_CYC;
  // A single-beat configuration still needs a 1-bit counter to exist.
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    data_q,  data_d;
  logic [7:0]      shift_q, shift_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [127:0]    out_q,   out_d;

  logic [127:0]    w_sub;
  logic            w_last;
  logic            w_unused_key;

  // Only the top key byte carries the shift; the rest is intentionally ignored.
  assign w_unused_key = ^key[119:0];

  assign w_last = (cnt_q == CW'(NBEATS - 1));

  // Subtract the shift from the bytes of the current beat; beat 0 is the MSB end.
  always_comb begin
    w_sub = data_q;
    for (int i = 0; i < 16; i++) begin
      if (CW'(i / BYTES_PER_CYC) == cnt_q) begin
        w_sub[127-8*i -: 8] = data_q[127-8*i -: 8] - shift_q;
      end
    end
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE sequencing.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = cae_in;
          shift_d = key[127:120];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = w_sub;
        if (w_last) begin
          cnt_d   = '0;
          out_d   = w_sub;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef CAE_ZEROIZE_EN
          data_d  = '0;
          shift_d = '0;
          out_d   = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, discarding any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // in_ready is forced low while reset is held so nothing is accepted during reset.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign cae_out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_caeser_inv_lyr.sv
`default_nettype none
// ============================================================================
// Module      : tb_caeser_inv_lyr
// Description : Directed self-checking bench for caeser_inv_lyr (default
//               BYTES_PER_CYC=4, so out_valid rises 5 edges after accept).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_caeser_inv_lyr;

  localparam int NBEATS = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cae_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cae_out;
  logic         busy;

  int checks;
  int failures;

  caeser_inv_lyr u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cae_in    (cae_in),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cae_out   (cae_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wise add of the shift: the encryption-path Caesar layer.
  function automatic logic [127:0] enc_caesar(input logic [127:0] p, input logic [7:0] s);
    logic [127:0] c;
    for (int i = 0; i < 16; i++) c[8*i +: 8] = p[8*i +: 8] + s;
    return c;
  endfunction

  // Accept one block, optionally swap the key after accept, wait (bounded)
  // for out_valid, capture the result, then complete the output handshake.
  // edges = clock edges from accept to out_valid (accept edge counts as 1),
  // or -1 if out_valid never came.
  task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                           input logic [127:0] k_after,
                           output logic [127:0] res, output int edges);
    @(negedge clk);
    cae_in    = d;
    key       = k;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key      = k_after;
    cae_in   = ~d;
    edges    = 1;
    while (!out_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) edges = -1;
    res = cae_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cae_in = '0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (cae_out !== 128'h0) begin failures++; $display("FAIL reset_cae_out: got %h expected 0", cae_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_borrow;
    logic [127:0] res;
    int           e;
    run_block(128'h0, {8'h01, 120'h0}, {8'h01, 120'h0}, res, e);
    checks++;
    if (e != NBEATS + 1) begin failures++; $display("FAIL borrow_latency: got %0d expected %0d", e, NBEATS + 1); end
    checks++;
    if (res !== {16{8'hFF}}) begin failures++; $display("FAIL borrow_data: got %h expected %h", res, {16{8'hFF}}); end
  endtask

  task automatic test_vector;
    logic [127:0] res;
    int           e;
    run_block(128'h00112233445566778899AABBCCDDEEFF, {8'h10, 120'h0},
              {8'h10, 120'h0}, res, e);
    checks++;
    if (res !== 128'hF0011223344556677889_9AABBCCDDEEF || e != NBEATS + 1) begin
      failures++; $display("FAIL vector_basic: got %h (edges %0d) expected f00112233445566778899aabbccddeef", res, e);
    end
    run_block(128'h00112233445566778899AABBCCDDEEFF, {8'h10, 120'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5},
              {8'h10, 120'h0}, res, e);
    checks++;
    if (res !== 128'hF0011223344556677889_9AABBCCDDEEF) begin
      failures++; $display("FAIL vector_low_key: got %h expected f00112233445566778899aabbccddeef", res);
    end
    run_block(128'h00112233445566778899AABBCCDDEEFF, {8'h10, 120'h0},
              {8'h77, 120'h123}, res, e);
    checks++;
    if (res !== 128'hF0011223344556677889_9AABBCCDDEEF) begin
      failures++; $display("FAIL vector_key_after: got %h expected f00112233445566778899aabbccddeef", res);
    end
  endtask

  task automatic test_shift0;
    logic [127:0] res;
    int           e;
    run_block(128'h0123456789ABCDEF_FEDCBA9876543210, 128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
              128'h0, res, e);
    checks++;
    if (res !== 128'h0123456789ABCDEF_FEDCBA9876543210 || e != NBEATS + 1) begin
      failures++; $display("FAIL shift0: got %h (edges %0d) expected 0123456789abcdeffedcba9876543210", res, e);
    end
  endtask

  task automatic test_roundtrip;
    logic [127:0] p, res;
    logic [7:0]   s;
    int           e, bad;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      s = 8'($urandom);
      run_block(enc_caesar(p, s), {s, 24'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
                {128{1'b0}}, res, e);
      if (res !== p || e != NBEATS + 1) begin
        if (bad < 4) $display("FAIL roundtrip[%0d]: got %h expected %h (shift %h, edges %0d)", n, res, p, s, e);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL roundtrip_total: got %0d bad blocks expected 0", bad); end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp_a, exp_b;
    int           e, bad;
    exp_a = 128'h5E5E_5E5E_5E5E_5E5E_0F0F_0F0F_0F0F_0F0F;  // 0x60 - 2, 0x11 - 2
    exp_b = 128'hFD00_0102_0304_0506_0708_090A_0B0C_0D0E;  // each byte - 3
    @(negedge clk);
    cae_in = 128'h6060_6060_6060_6060_1111_1111_1111_1111;
    key = {8'h02, 120'h0}; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 1;
    while (!out_valid && e < 60) begin @(posedge clk); #1; e++; end
    checks++;
    if (e != NBEATS + 1) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", e, NBEATS + 1); end
    @(negedge clk);
    cae_in = 128'h0003_0405_0607_0809_0A0B_0C0D_0E0F_1011;
    key = {8'h03, 120'h0}; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || cae_out !== exp_a || in_ready !== 1'b0 || busy !== 1'b1) begin
        if (bad == 0) $display("FAIL bp_hold[%0d]: got ov=%b ir=%b busy=%b data=%h expected ov=1 ir=0 busy=1 data=%h",
                               i, out_valid, in_ready, busy, cae_out, exp_a);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold_total: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release: got ov=%b ir=%b busy=%b expected ov=0 ir=1 busy=0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 1;
    while (!out_valid && e < 60) begin @(posedge clk); #1; e++; end
    checks++;
    if (cae_out !== exp_b || e != NBEATS + 1) begin
      failures++; $display("FAIL bp_second_block: got %h (edges %0d) expected %h", cae_out, e, exp_b);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [127:0] res;
    int           e;
    @(negedge clk);
    cae_in = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    key = {8'h0A, 120'h0}; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL abort_immediate: got ov=%b busy=%b ir=%b expected 0 0 0", out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_pulse: got ov=%b busy=%b expected 0 0", out_valid, busy);
    end
    run_block(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, {8'h21, 120'h0}, 128'h0, res, e);
    checks++;
    if (res !== 128'hF113_3557_799B_BDCF_EECC_AA88_6644_2200 || e != NBEATS + 1) begin
      failures++; $display("FAIL abort_next_block: got %h (edges %0d) expected f1133557799bbdcfeecc aa8866442200", res, e);
    end
  endtask

  task automatic test_retain;
    logic [127:0] res, exp_after;
    int           e;
    run_block(128'h8080_8080_8080_8080_8080_8080_8080_8080, {8'h80, 120'h0}, 128'h0, res, e);
    checks++;
    if (res !== 128'h0) begin failures++; $display("FAIL retain_data0: got %h expected 0", res); end
    run_block(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, {8'h01, 120'h0}, 128'h0, res, e);
`ifdef CAE_ZEROIZE_EN
    exp_after = 128'h0;
`else
    exp_after = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
`endif
    checks++;
    if (cae_out !== exp_after || out_valid !== 1'b0) begin
      failures++; $display("FAIL retain_after_hs: got %h ov=%b expected %h ov=0", cae_out, out_valid, exp_after);
    end
  endtask

  task automatic test_back_to_back;
    int first, second, cyc;
    first = -1; second = -1;
    @(negedge clk);
    cae_in = 128'h0; key = {8'h01, 120'h0}; in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 30 && second < 0; cyc++) begin
      if (in_ready && in_valid) begin
        if (first < 0) first = cyc;
        else           second = cyc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) != NBEATS + 2) begin
      failures++; $display("FAIL b2b_period: got %0d expected %0d", second - first, NBEATS + 2);
    end
    repeat (NBEATS + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_borrow;
    test_vector;
    test_shift0;
    test_backpressure;
    test_reset_mid_run;
    test_retain;
    test_back_to_back;
    test_roundtrip;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
